// File: rtl/traffic_light_fsm.sv
// Traffic light controller stepping on synchronized slow-clock ticks.
// Optional pedestrian WALK phase is built when PED_WALK_EN is defined.
module traffic_light_fsm #(
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int RED_TICKS    = 5,
  parameter int WALK_TICKS   = 4
) (
  input  logic       in_clk,
  input  logic       reset_n,
  input  logic       slow_clk,
  input  logic       ped_req,
  output logic [2:0] light,
  output logic       walk,
  output logic [1:0] state_dbg,
  output logic       tick
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_RED    = 2'b10,
    ST_WALK   = 2'b11
  } state_t;

  localparam logic [3:0] GREEN_LAST  = 4'(GREEN_TICKS - 1);
  localparam logic [3:0] YELLOW_LAST = 4'(YELLOW_TICKS - 1);
  localparam logic [3:0] RED_LAST    = 4'(RED_TICKS - 1);
  localparam logic [3:0] WALK_LAST   = 4'(WALK_TICKS - 1);

  state_t     state_reg, state_next;
  logic [3:0] timer_reg, timer_next;
  logic [3:0] timer_last;
  logic [1:0] slow_sync_reg;
  logic       slow_hist_reg;

  // slow_clk is treated as data: two sync stages, then a history bit for edge detect
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      slow_sync_reg <= 2'b00;
      slow_hist_reg <= 1'b0;
    end else begin
      slow_sync_reg <= {slow_sync_reg[0], slow_clk};
      slow_hist_reg <= slow_sync_reg[1];
    end
  end

  assign tick = slow_sync_reg[1] & ~slow_hist_reg;

`ifdef PED_WALK_EN
  logic [1:0] ped_sync_reg;
  logic       ped_pending_reg, ped_pending_next;

  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_sync_reg    <= 2'b00;
      ped_pending_reg <= 1'b0;
    end else begin
      ped_sync_reg    <= {ped_sync_reg[0], ped_req};
      ped_pending_reg <= ped_pending_next;
    end
  end
`else
  logic ped_req_unused;
  assign ped_req_unused = ped_req;
`endif

  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_GREEN;
      timer_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  always_comb begin
    case (state_reg)
      ST_GREEN:  timer_last = GREEN_LAST;
      ST_YELLOW: timer_last = YELLOW_LAST;
      ST_RED:    timer_last = RED_LAST;
      default:   timer_last = WALK_LAST;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
`ifdef PED_WALK_EN
    ped_pending_next = ped_pending_reg | ped_sync_reg[1];
`endif
    if (tick) begin
      if (timer_reg == timer_last) begin
        timer_next = 4'd0;
        case (state_reg)
          ST_GREEN:  state_next = ST_YELLOW;
          ST_YELLOW: state_next = ST_RED;
          ST_RED: begin
`ifdef PED_WALK_EN
            if (ped_pending_reg) begin
              state_next       = ST_WALK;
              // a request seen on this very edge stays pending for the next RED
              ped_pending_next = ped_sync_reg[1];
            end else begin
              state_next = ST_GREEN;
            end
`else
            state_next = ST_GREEN;
`endif
          end
          default:   state_next = ST_GREEN;
        endcase
      end else begin
        timer_next = timer_reg + 4'd1;
      end
    end
  end

  always_comb begin
    light = 3'b001;
    walk  = 1'b0;
    case (state_reg)
      ST_GREEN:  light = 3'b001;
      ST_YELLOW: light = 3'b010;
      ST_RED:    light = 3'b100;
      default: begin
        light = 3'b100;
`ifdef PED_WALK_EN
        walk = 1'b1;
`endif
      end
    endcase
  end

  assign state_dbg = state_reg;

endmodule
